// File: rtl/w5300_udp_tx_sequencer.sv
// Per-socket UDP transmit sequencer: walks a command LUT, issues each entry to the W5300
// host-bus master, then polls Sn_CR until the chip accepts the command.
module w5300_udp_tx_sequencer #(
  parameter int         N           = 0,
  parameter logic [5:0] FIRST_INDEX = 6'h01,
  parameter logic [5:0] LAST_INDEX  = 6'h10,
  parameter int         POLL_LIMIT  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [5:0]  lut_index,
  input  logic [26:0] lut_data,
  output logic        bus_req,
  output logic        bus_rd,
  output logic [9:0]  bus_addr,
  output logic [15:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata,
  output logic [15:0] last_rdata
);

  localparam int          SN_CR_INT    = 32'h202 + 32'h40 * N;
  localparam logic [9:0]  SN_CR_ADDR   = SN_CR_INT[9:0];
  localparam logic [15:0] POLL_LIMIT_W = POLL_LIMIT[15:0];
  localparam logic [9:0]  HOLE_ADDR    = 10'h3ff;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_NEXT,
    S_POLL,
    S_PWAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        ent_rd;
  logic [9:0]  ent_addr;
  logic [15:0] ent_data;
  logic        ent_hole;
  logic        at_last;
  logic        cr_sent;
  logic [15:0] poll_cnt;

  assign {ent_rd, ent_addr, ent_data} = lut_data;
  assign ent_hole = (ent_addr == HOLE_ADDR);
  assign at_last  = (lut_index == LAST_INDEX);

  // Completion pulses are decoded straight from the state register, so they last exactly one cycle.
  assign done  = (state == S_DONE);
  assign error = (state == S_ERR);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: state_nx = ent_hole ? S_NEXT : S_ISSUE;
      S_ISSUE: if (bus_ack) state_nx = S_NEXT;
      S_NEXT: begin
        if (at_last) state_nx = cr_sent ? S_POLL : S_DONE;
        else         state_nx = S_FETCH;
      end
      S_POLL:  state_nx = S_PWAIT;
      S_PWAIT: begin
        if (bus_ack) begin
          if (bus_rdata == 16'h0000)        state_nx = S_DONE;
          else if (poll_cnt == POLL_LIMIT_W) state_nx = S_ERR;
          else                              state_nx = S_POLL;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      lut_index  <= FIRST_INDEX;
      bus_req    <= 1'b0;
      bus_rd     <= 1'b0;
      bus_addr   <= 10'h000;
      bus_wdata  <= 16'h0000;
      last_rdata <= 16'h0000;
      cr_sent    <= 1'b0;
      poll_cnt   <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lut_index <= FIRST_INDEX;
            busy      <= 1'b1;
            cr_sent   <= 1'b0;
            poll_cnt  <= 16'h0000;
          end
        end
        S_FETCH: begin
          // Unpopulated entries fall through to NEXT without touching the bus.
          if (!ent_hole) begin
            bus_req   <= 1'b1;
            bus_rd    <= ent_rd;
            bus_addr  <= ent_addr;
            bus_wdata <= ent_data;
          end
        end
        S_ISSUE: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (bus_rd) last_rdata <= bus_rdata;
            if (!bus_rd && (bus_addr == SN_CR_ADDR)) cr_sent <= 1'b1;
          end
        end
        S_NEXT: begin
          if (!at_last) lut_index <= lut_index + 6'd1;
        end
        S_POLL: begin
          bus_req   <= 1'b1;
          bus_rd    <= 1'b1;
          bus_addr  <= SN_CR_ADDR;
          bus_wdata <= 16'h0000;
          poll_cnt  <= poll_cnt + 16'd1;
        end
        S_PWAIT: begin
          if (bus_ack) begin
            bus_req    <= 1'b0;
            last_rdata <= bus_rdata;
          end
        end
        S_DONE:  busy <= 1'b0;
        S_ERR:   busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_w5300_udp_tx_sequencer.sv
// Bench for w5300_udp_tx_sequencer: two instances (N=0 with POLL_LIMIT=4, N=2 with the default limit),
// a bus responder, and a transaction-level model checked on every negedge.
module tb_w5300_udp_tx_sequencer;

  localparam logic [5:0] FIRST = 6'h01;
  localparam logic [5:0] LAST  = 6'h10;

  typedef struct packed {
    logic        rd;
    logic [9:0]  addr;
    logic [15:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start      [2] = '{1'b0, 1'b0};
  logic        busy       [2];
  logic        done       [2];
  logic        error      [2];
  logic [5:0]  lut_index  [2];
  logic [26:0] lut_data   [2];
  logic        bus_req    [2];
  logic        bus_rd     [2];
  logic [9:0]  bus_addr   [2];
  logic [15:0] bus_wdata  [2];
  logic        bus_ack    [2] = '{1'b0, 1'b0};
  logic [15:0] bus_rdata  [2] = '{16'h0000, 16'h0000};
  logic [15:0] last_rdata [2];

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] cr_of(input int inst);
    return (inst == 0) ? 10'h202 : 10'h282;
  endfunction

  // Command LUT: 12 writes, one read at index 03, holes at 05, 0e and 0f, Sn_CR SEND last.
  function automatic logic [26:0] lut_entry(input logic [5:0] idx, input logic [9:0] cr);
    case (idx)
      6'h01:   return {1'b0, 10'h200, 16'h0002};
      6'h02:   return {1'b0, 10'h20c, 16'h1389};
      6'h03:   return {1'b1, 10'h018, 16'h0000};
      6'h04:   return {1'b0, 10'h212, 16'hc0a8};
      6'h06:   return {1'b0, 10'h214, 16'h0164};
      6'h07:   return {1'b0, 10'h216, 16'h1388};
      6'h08:   return {1'b0, 10'h218, 16'h0001};
      6'h09:   return {1'b0, 10'h21a, 16'h0002};
      6'h0a:   return {1'b0, 10'h220, 16'h0010};
      6'h0b:   return {1'b0, 10'h222, 16'h0000};
      6'h0c:   return {1'b0, 10'h224, 16'h0020};
      6'h0d:   return {1'b0, 10'h226, 16'h0400};
      6'h10:   return {1'b0, cr,      16'h0020};
      default: return {1'b0, 10'h3ff, 16'h0000};
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    w5300_udp_tx_sequencer #(
      .N           (g * 2),
      .FIRST_INDEX (FIRST),
      .LAST_INDEX  (LAST),
      .POLL_LIMIT  ((g == 0) ? 4 : 1000)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .error      (error[g]),
      .lut_index  (lut_index[g]),
      .lut_data   (lut_data[g]),
      .bus_req    (bus_req[g]),
      .bus_rd     (bus_rd[g]),
      .bus_addr   (bus_addr[g]),
      .bus_wdata  (bus_wdata[g]),
      .bus_ack    (bus_ack[g]),
      .bus_rdata  (bus_rdata[g]),
      .last_rdata (last_rdata[g])
    );
    assign lut_data[g] = lut_entry(lut_index[g], cr_of(g));
  end

  // Responder controls
  int   active   = 0;
  int   ack_dly  = 2;
  int   nz       = 0;
  int   cr_reads = 0;
  int   wait_cnt = 0;
  logic spur     = 1'b0;

  // Bus master stand-in: acks ack_dly cycles after req; Sn_CR reads nz times nonzero, then 0.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (i != active) begin
        bus_ack[i]   = 1'b0;
        bus_rdata[i] = 16'h0000;
      end
    end
    if (bus_req[active] && !bus_ack[active]) begin
      wait_cnt++;
      if (wait_cnt >= ack_dly) begin
        wait_cnt        = 0;
        bus_ack[active] = 1'b1;
        if (bus_rd[active] && bus_addr[active] == cr_of(active)) begin
          cr_reads++;
          bus_rdata[active] = (cr_reads <= nz) ? 16'h0020 : 16'h0000;
        end else if (bus_rd[active]) begin
          bus_rdata[active] = 16'hc0a8;
        end else begin
          bus_rdata[active] = 16'hdead;
        end
      end
    end else if (spur) begin
      bus_ack[active]   = 1'b1;
      bus_rdata[active] = 16'h1234;
    end else begin
      bus_ack[active] = 1'b0;
      wait_cnt        = 0;
    end
  end

  // Model state and compare process
  txn_t        exp_q[$];
  logic [15:0] model_last [2] = '{16'h0000, 16'h0000};
  int          done_cnt, err_cnt, busy_cyc, txn_cnt, cr_rd_cnt;
  logic        prev_hold = 1'b0;
  txn_t        prev_txn;
  txn_t        cur_txn;
  txn_t        exp_txn;
  int          ca;

  always @(negedge clk) begin
    ca = active;
    if (rst) begin
      model_last[0] = 16'h0000;
      model_last[1] = 16'h0000;
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      cur_txn = {bus_rd[ca], bus_addr[ca], bus_wdata[ca]};
      check("last_rdata", last_rdata[ca], model_last[ca]);
      check("idx_range", (lut_index[ca] >= FIRST) && (lut_index[ca] <= LAST), 1);
      check("done_err_excl", done[ca] & error[ca], 0);
      check("idle_inst_quiet", bus_req[1-ca] | busy[1-ca], 0);
      if (done[ca])  done_cnt++;
      if (error[ca]) err_cnt++;
      if (busy[ca])  busy_cyc++;
      if (prev_hold && bus_req[ca]) check("hold_stable", cur_txn, prev_txn);
      if (bus_req[ca] && bus_ack[ca]) begin
        txn_cnt++;
        if (bus_rd[ca] && bus_addr[ca] == cr_of(ca)) cr_rd_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_txn: got %0h expected none at %0t", cur_txn, $time);
        end else begin
          exp_txn = exp_q.pop_front();
          check("txn", cur_txn, exp_txn);
        end
        if (bus_rd[ca]) model_last[ca] = bus_rdata[ca];
      end
      prev_hold = bus_req[ca] && !bus_ack[ca];
      prev_txn  = cur_txn;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one packet on instance inst; builds expectations from the LUT and the poll rules.
  task automatic run_seq(input int inst, input int dly, input int nzv, input int limit, input bit extra,
                         output int o_txn, output int o_cr, output int o_busy);
    int   n_tx = 0;
    int   n_hole = 0;
    int   exp_polls;
    bit   exp_done;
    int   exp_busy;
    int   cyc;
    bit   seen04 = 1'b0;
    txn_t e;
    active   = inst;
    ack_dly  = dly;
    nz       = nzv;
    cr_reads = 0;
    for (int i = FIRST; i <= LAST; i++) begin
      e = lut_entry(i[5:0], cr_of(inst));
      if (e.addr == 10'h3ff) n_hole++;
      else begin
        n_tx++;
        exp_q.push_back(e);
      end
    end
    exp_done  = (nzv < limit);
    exp_polls = exp_done ? nzv + 1 : limit;
    for (int p = 0; p < exp_polls; p++) exp_q.push_back({1'b1, cr_of(inst), 16'h0000});
    exp_busy = n_tx * (2 + dly) + 2 * n_hole + exp_polls * (1 + dly) + 1;
    done_cnt = 0; err_cnt = 0; busy_cyc = 0; txn_cnt = 0; cr_rd_cnt = 0;
    start[inst] = 1'b1;
    tick();
    start[inst] = 1'b0;
    cyc = 0;
    while (!(done[inst] || error[inst]) && cyc < 3000) begin
      start[inst] = extra && (cyc == 10);
      if (bus_req[inst] && bus_addr[inst] == 10'h212 && !seen04) begin
        seen04 = 1'b1;
        check("rd03_before_04", last_rdata[inst], 16'hc0a8);
      end
      tick();
      cyc++;
    end
    check("no_timeout", cyc < 3000, 1);
    start[inst] = extra;
    tick();
    start[inst] = 1'b0;
    repeat (5) tick();
    check("queue_drained", exp_q.size(), 0);
    check("done_count", done_cnt, exp_done ? 1 : 0);
    check("error_count", err_cnt, exp_done ? 0 : 1);
    check("busy_end", busy[inst], 0);
    check("busy_cycles", busy_cyc, exp_busy);
    check("cr_reads", cr_rd_cnt, exp_polls);
    check("txn_count", txn_cnt, n_tx + exp_polls);
    o_txn  = txn_cnt;
    o_cr   = cr_rd_cnt;
    o_busy = busy_cyc;
  endtask

  initial begin
    int   t_txn, t_cr, t_busy, cyc;
    rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", busy[i], 0);
      check("rst_done", done[i], 0);
      check("rst_error", error[i], 0);
      check("rst_req", bus_req[i], 0);
      check("rst_rd", bus_rd[i], 0);
      check("rst_addr", bus_addr[i], 10'h000);
      check("rst_wdata", bus_wdata[i], 16'h0000);
      check("rst_index", lut_index[i], 6'h01);
      check("rst_last_rdata", last_rdata[i], 16'h0000);
    end
    rst = 1'b0;
    tick();

    // Ack with no request outstanding must not be captured
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    tick();
    check("spur_last_rdata", last_rdata[0], 16'h0000);
    check("spur_busy", busy[0], 0);

    // Default LUT, ack after 2 cycles, Sn_CR 0x0020 twice then 0; stray starts ignored
    run_seq(0, 2, 2, 4, 1'b1, t_txn, t_cr, t_busy);
    check("main_txns", t_txn, 16);
    check("main_cr_reads", t_cr, 3);
    check("main_busy", t_busy, 68);
    check("main_last_rdata", last_rdata[0], 16'h0000);

    // Same-cycle acks: minimum cost per entry
    run_seq(0, 1, 0, 4, 1'b0, t_txn, t_cr, t_busy);
    check("fast_busy", t_busy, 48);
    check("fast_txns", t_txn, 14);

    // Sn_CR never clears: POLL_LIMIT=4 reads, then error
    run_seq(0, 2, 1000, 4, 1'b0, t_txn, t_cr, t_busy);
    check("err_cr_reads", t_cr, 4);
    check("err_last_rdata", last_rdata[0], 16'h0020);

    // Reset while a request is outstanding
    active  = 0;
    ack_dly = 3;
    nz      = 0;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    cyc = 0;
    while (!bus_req[0] && cyc < 50) begin
      tick();
      cyc++;
    end
    check("req_before_rst", bus_req[0], 1);
    rst = 1'b1;
    tick();
    check("midrst_req", bus_req[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_index", lut_index[0], 6'h01);
    rst = 1'b0;
    tick();
    tick();
    check("postrst_idle", busy[0] | bus_req[0], 0);
    run_seq(0, 2, 1, 4, 1'b0, t_txn, t_cr, t_busy);
    check("postrst_cr_reads", t_cr, 2);

    // Socket 2 polls Sn_CR at 0x282
    run_seq(1, 2, 1, 1000, 1'b0, t_txn, t_cr, t_busy);
    check("n2_cr_reads", t_cr, 2);
    check("n2_cr_addr", bus_addr[1], 10'h282);
    check("n2_done_busy", busy[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
